// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational 4-bit ALU between two requesters. A round-robin
// grant picks one requester in IDLE, its operands are latched and presented to
// the ALU for one cycle (EXEC). The ALU result is registered and returned on a
// valid/ready response channel tagged with the requester id (RESP).
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op    requester N operands and opcode
//   alu_a, alu_b, alu_op       registered drive to the shared ALU
//   alu_result                 combinational ALU result
//   resp_valid/ready           response handshake
//   resp_id, resp_data         owner and registered result of the response
//   busy                       high whenever the FSM is not in IDLE
//   done_cnt                   completed responses, wraps mod 2^CNT_W
module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic [OP_W-1:0]     op_p0;
  logic                id_p0;
  logic                last_grant;
  logic                win0;
  logic                win1;

  // A lone requester always wins; under contention the one not served last wins.
  always_comb begin
    win0 = req0_valid && (!req1_valid || last_grant);
    win1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == IDLE) && !rst && win0;
  assign req1_ready = (state == IDLE) && !rst && win1;

  assign alu_a  = a_p0;
  assign alu_b  = b_p0;
  assign alu_op = op_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_p0       <= '0;
      b_p0       <= '0;
      op_p0      <= '0;
      id_p0      <= 1'b0;
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      busy       <= 1'b0;
      done_cnt   <= '0;
    end else begin
      unique case (state)
        // Stage 0: grant and latch operands of the winning requester.
        IDLE: begin
          if (req0_ready || req1_ready) begin
            a_p0       <= req1_ready ? req1_a  : req0_a;
            b_p0       <= req1_ready ? req1_b  : req0_b;
            op_p0      <= req1_ready ? req1_op : req0_op;
            id_p0      <= req1_ready;
            last_grant <= req1_ready;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        // Stage 1: ALU sees the latched operands; capture its result.
        EXEC: begin
          resp_data  <= alu_result;
          resp_id    <= id_p0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // Stage 2: hold the response until the consumer takes it.
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            done_cnt   <= done_cnt + CNT_W'(1);
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Directed bench for alu_arbiter. A small behavioural ALU closes the loop from
// alu_a/alu_b/alu_op back to alu_result. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit after the inputs settle.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       resp_valid, resp_ready, resp_id;
  logic [3:0] resp_data;
  logic       busy;
  logic [7:0] done_cnt;

  int vectors = 0;
  int errors  = 0;

  alu_arbiter #(.DATA_W(4), .OP_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  // Reference ALU core: add, sub, not A, and, or, xor, less-than, equal.
  always_comb begin
    alu_result = 4'h0;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = ~alu_a;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a ^ alu_b;
      3'b110: alu_result = {3'b000, (alu_a < alu_b)};
      default: alu_result = {3'b000, (alu_a == alu_b)};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = 4'h0; req0_b = 4'h0; req0_op = 3'b000;
    req1_valid = 1'b0; req1_a = 4'h0; req1_b = 4'h0; req1_op = 3'b000;
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
    end
    vectors++;
    if ({busy, resp_valid, resp_id, resp_data, alu_a, alu_b, alu_op, done_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rv=%b id=%b d=%h a=%h b=%h op=%b cnt=%0d expected all 0",
               busy, resp_valid, resp_id, resp_data, alu_a, alu_b, alu_op, done_cnt);
    end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_op = 3'b000;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL add_ready: got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    vectors++;
    if ({alu_a, alu_b, alu_op, busy, resp_valid} !== {4'd3, 4'd5, 3'b000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_exec: got a=%h b=%h op=%b busy=%b rv=%b expected a=3 b=5 op=000 busy=1 rv=0",
               alu_a, alu_b, alu_op, busy, resp_valid);
    end
    tick();
    vectors++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 4'h8}) begin
      errors++;
      $display("FAIL add_resp: got rv=%b id=%b d=%h expected rv=1 id=0 d=8", resp_valid, resp_id, resp_data);
    end
    tick();
    vectors++;
    if ({resp_valid, busy, done_cnt} !== {1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL add_done: got rv=%b busy=%b cnt=%0d expected rv=0 busy=0 cnt=1", resp_valid, busy, done_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic       exp_id;
    logic [3:0] exp_data;
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd5; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd6; req1_op = 3'b111;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id   = k[0];
      exp_data = exp_id ? 4'h1 : 4'hD;
      #1;
      vectors++;
      if ({req1_ready, req0_ready, done_cnt} !== {exp_id, ~exp_id, 8'(k)}) begin
        errors++;
        $display("FAIL b2b_grant%0d: got ready=%b%b cnt=%0d expected ready=%b%b cnt=%0d",
                 k, req1_ready, req0_ready, done_cnt, exp_id, ~exp_id, k);
      end
      tick();
      tick();
      vectors++;
      if ({resp_valid, resp_id, resp_data} !== {1'b1, exp_id, exp_data}) begin
        errors++;
        $display("FAIL b2b_resp%0d: got rv=%b id=%b d=%h expected rv=1 id=%b d=%h",
                 k, resp_valid, resp_id, resp_data, exp_id, exp_data);
      end
      tick();
    end
    clear_inputs();
    #1;
    vectors++;
    if ({busy, done_cnt} !== {1'b0, 8'd4}) begin
      errors++;
      $display("FAIL b2b_count: got busy=%b cnt=%0d expected busy=0 cnt=4", busy, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    // last_grant is 1 here, so req0 wins the contention.
    req0_valid = 1'b1; req0_a = 4'h9; req0_b = 4'h3; req0_op = 3'b101;
    req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h1; req1_op = 3'b000;
    resp_ready = 1'b0;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      req1_a = 4'(i + 7);
      #1;
      vectors++;
      if ({resp_valid, resp_id, resp_data, req1_ready, req0_ready, busy, done_cnt}
          !== {1'b1, 1'b0, 4'hA, 2'b00, 1'b1, 8'd4}) begin
        errors++;
        $display("FAIL bp_hold%0d: got rv=%b id=%b d=%h ready=%b%b busy=%b cnt=%0d expected rv=1 id=0 d=a ready=00 busy=1 cnt=4",
                 i, resp_valid, resp_id, resp_data, req1_ready, req0_ready, busy, done_cnt);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    vectors++;
    if ({resp_valid, done_cnt} !== {1'b0, 8'd5}) begin
      errors++;
      $display("FAIL bp_release: got rv=%b cnt=%0d expected rv=0 cnt=5", resp_valid, done_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_op();
    // Reset while in EXEC.
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 3'b000;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, resp_valid, resp_id, resp_data, alu_a, alu_b, alu_op, done_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL rst_exec: got busy=%b rv=%b id=%b d=%h a=%h b=%h op=%b cnt=%0d expected all 0",
               busy, resp_valid, resp_id, resp_data, alu_a, alu_b, alu_op, done_cnt);
    end
    // Reset while in RESP, with resp_ready high in the same cycle.
    req0_valid = 1'b1; req0_a = 4'h4; req0_b = 4'h2; req0_op = 3'b000;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    vectors++;
    if ({resp_valid, resp_data} !== {1'b1, 4'h6}) begin
      errors++;
      $display("FAIL rst_pre_resp: got rv=%b d=%h expected rv=1 d=6", resp_valid, resp_data);
    end
    rst = 1'b1;
    resp_ready = 1'b1;
    tick();
    rst = 1'b0;
    resp_ready = 1'b0;
    #1;
    vectors++;
    if ({busy, resp_valid, resp_id, resp_data, alu_a, alu_b, alu_op, done_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL rst_resp: got busy=%b rv=%b id=%b d=%h a=%h b=%h op=%b cnt=%0d expected all 0",
               busy, resp_valid, resp_id, resp_data, alu_a, alu_b, alu_op, done_cnt);
    end
    // req1 alone is granted straight away.
    req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h2; req1_op = 3'b100;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rst_req1_grant: got %b expected 10", {req1_ready, req0_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    resp_ready = 1'b1;
    vectors++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 4'h7}) begin
      errors++;
      $display("FAIL rst_req1_resp: got rv=%b id=%b d=%h expected rv=1 id=1 d=7", resp_valid, resp_id, resp_data);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_fairness_idle();
    // resp_ready high in IDLE must not bump the counter.
    resp_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, done_cnt} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL idle_resp_ready: got busy=%b cnt=%0d expected busy=0 cnt=1", busy, done_cnt);
    end
    // req1 was served last, yet as the only requester it still wins.
    req1_valid = 1'b1; req1_a = 4'hC; req1_b = 4'hA; req1_op = 3'b011;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL fair_grant: got %b expected 10", {req1_ready, req0_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    vectors++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 4'h8}) begin
      errors++;
      $display("FAIL fair_resp: got rv=%b id=%b d=%h expected rv=1 id=1 d=8", resp_valid, resp_id, resp_data);
    end
    tick();
    vectors++;
    if (done_cnt !== 8'd2) begin
      errors++;
      $display("FAIL fair_count: got %0d expected 2", done_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_count_wrap();
    do_reset();
    req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h0; req0_op = 3'b010;
    resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      tick();
      vectors++;
      if ({resp_valid, resp_data, done_cnt} !== {1'b1, 4'hA, 8'(i)}) begin
        errors++;
        $display("FAIL wrap_resp%0d: got rv=%b d=%h cnt=%0d expected rv=1 d=a cnt=%0d",
                 i, resp_valid, resp_data, done_cnt, i);
      end
      if (i == 255) req0_valid = 1'b0;
      tick();
    end
    vectors++;
    if ({busy, resp_valid, done_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL wrap_count: got busy=%b rv=%b cnt=%0d expected busy=0 rv=0 cnt=0", busy, resp_valid, done_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_fairness_idle();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit combinational ALU core (ops 000..111: add, sub, not A, and, or, xor, less-than flag, equal flag) between two requesters.
- Each requester submits (a, b, op) over a valid/ready handshake. The block grants round-robin, latches the operands, drives the shared ALU for one cycle, and registers the 4-bit result.
- It returns the result on a valid/ready response channel tagged with the requester id.
- Sits between the control/test front end and the ALU datapath, ahead of the 7-segment display path.

Parameters:
- DATA_W, 4, operand and result width.
- OP_W, 3, ALU opcode width.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  DATA_W  requester 0 operand A.
- req0_b  input  DATA_W  requester 0 operand B.
- req0_op  input  OP_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a  output  DATA_W  operand A to the shared ALU.
- alu_b  output  DATA_W  operand B to the shared ALU.
- alu_op  output  OP_W  opcode to the shared ALU.
- alu_result  input  DATA_W  combinational ALU result (raw two's-complement value, pre-display).
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  1  requester that owns resp_data.
- resp_data  output  DATA_W  registered ALU result.
- busy  output  1  high whenever state is not IDLE.
- done_cnt  output  CNT_W  number of completed responses.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - Operand/op registers = 0, so alu_a=0, alu_b=0, alu_op=000.
  - resp_valid=0, resp_id=0, resp_data=0, busy=0, done_cnt=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready are 0 while rst is high.
- State machine, IDLE -> EXEC -> RESP -> IDLE:
  - IDLE:
    - Winner selection: if exactly one reqN_valid is high, that requester wins. If both are high, the requester != last_grant wins.
    - reqN_ready is combinational: it equals the winner's valid, in IDLE only. At most one ready is high per cycle.
    - On handshake: latch a, b, op and the id; set last_grant=id; go to EXEC.
    - With no valid, stay in IDLE.
  - EXEC (exactly 1 cycle):
    - alu_a/alu_b/alu_op are driven from the latched registers. They are registered outputs, stable from the cycle after acceptance until the next acceptance.
    - At the end of the cycle, capture resp_data <= alu_result and resp_id <= latched id; set resp_valid <= 1; go to RESP.
  - RESP:
    - resp_valid=1; resp_data and resp_id are held stable.
    - Both reqN_ready are 0.
    - On resp_ready=1: resp_valid <= 0, done_cnt <= done_cnt+1 (wraps mod 2^CNT_W), go to IDLE.
    - If resp_ready=0: hold indefinitely, with no timeout.
- Latency and throughput:
  - Acceptance in cycle t gives resp_valid high in cycle t+2.
  - Minimum of 3 cycles per operation with resp_ready tied high. The next acceptance can occur in t+3.
- Requester rules:
  - Requesters must hold valid and operands until ready.
  - A requester that drops valid before ready is simply not granted. No state changes.
  - Operand changes on a non-granted requester are ignored.
- The block does no arithmetic. Results are whatever the ALU returns, truncated to DATA_W, wrap-around included.
- Reset mid-operation (rst in EXEC or RESP): the pending operation is discarded and no response is produced. All state returns to the reset values on the next edge; done_cnt is cleared.
- Simultaneous events:
  - resp_ready is only sampled in RESP. resp_ready high in IDLE/EXEC has no effect.
  - rst has priority over every handshake in the same cycle.

Test Plan:
- After reset, req0 only, a=3 b=5 op=000: req0_ready high in cycle 0; alu_a=3 alu_b=5 alu_op=000 in cycle 1; cycle 2 shows resp_valid=1, resp_id=0, resp_data=8. With resp_ready=1, done_cnt=1 in cycle 3.
- Both valid continuously, req0 (a=2 b=5 op=001), req1 (a=6 b=6 op=111), resp_ready=1:
  - Grants alternate 0,1,0,1.
  - Responses alternate resp_id=0 with data 4'hD and resp_id=1 with data 4'h1.
  - Acceptances are 3 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles in RESP: resp_valid, resp_id and resp_data are held unchanged; both ready stay 0; done_cnt is unchanged until resp_ready=1.
- Reset during EXEC, then during RESP: no response is observed, all outputs return to reset values, and the next req1-only request is granted immediately.
- done_cnt wrap: complete 256 operations (op=010, a=4'h5): each resp_data=4'hA, and done_cnt reads 0 after the 256th.
- Grant fairness after idle: req1 served last, then only req1 valid: req1 is still granted immediately, since an idle winner is not blocked by last_grant.
